// File: rtl/spatz_elem_seq_if.sv
// rtl/spatz_elem_seq_if.sv - request, beat and completion bundle of the element sequencer
interface spatz_elem_seq_if #(
    parameter int unsigned NrLanes = 4,
    parameter int unsigned VLEN    = 512,
    parameter int unsigned IdWidth = 3
);
    localparam int unsigned BeatBytes = 4 * NrLanes;
    localparam int unsigned VlWidth   = $clog2(VLEN + 1);

    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [IdWidth-1:0]   req_id_i;
    logic [VlWidth-1:0]   req_vl_i;
    logic [VlWidth-1:0]   req_vstart_i;
    logic [1:0]           req_vsew_i;
    logic [4:0]           req_vd_i;

    logic                 beat_valid_o;
    logic                 beat_ready_i;
    logic [IdWidth-1:0]   beat_id_o;
    logic [4:0]           beat_vd_o;
    logic [VlWidth-1:0]   beat_elem_idx_o;
    logic [BeatBytes-1:0] beat_be_o;
    logic                 beat_first_o;
    logic                 beat_last_o;

    logic                 done_o;
    logic [IdWidth-1:0]   done_id_o;
    logic                 err_o;

    modport slave (
        input  req_valid_i, req_id_i, req_vl_i, req_vstart_i, req_vsew_i, req_vd_i,
        input  beat_ready_i,
        output req_ready_o,
        output beat_valid_o, beat_id_o, beat_vd_o, beat_elem_idx_o, beat_be_o,
        output beat_first_o, beat_last_o,
        output done_o, done_id_o, err_o
    );

    modport master (
        output req_valid_i, req_id_i, req_vl_i, req_vstart_i, req_vsew_i, req_vd_i,
        output beat_ready_i,
        input  req_ready_o,
        input  beat_valid_o, beat_id_o, beat_vd_o, beat_elem_idx_o, beat_be_o,
        input  beat_first_o, beat_last_o,
        input  done_o, done_id_o, err_o
    );
endinterface

// File: rtl/spatz_elem_seq.sv
// rtl/spatz_elem_seq.sv - splits [vstart, vl) of one vector op into lane-wide byte-enabled beats
module spatz_elem_seq #(
    parameter int unsigned NrLanes = 4,
    parameter int unsigned VLEN    = 512,
    parameter int unsigned IdWidth = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    spatz_elem_seq_if.slave  bus
);
    localparam int unsigned BeatBytes = 4 * NrLanes;
    localparam int unsigned VlWidth   = $clog2(VLEN + 1);
    // One extra bit so idx + EPB past vl=VLEN never wraps.
    localparam int unsigned IW        = VlWidth + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    typedef logic [IW-1:0] idx_t;

    state_e               state_q;
    logic [IdWidth-1:0]   id_q;
    logic [4:0]           vd_q;
    idx_t                 vl_q;
    idx_t                 vstart_q;
    logic [1:0]           vsew_q;
    idx_t                 idx_q;
    logic                 beat_valid_q;
    logic [BeatBytes-1:0] be_q;
    logic                 first_q;
    logic                 last_q;
    logic                 done_q;
    logic                 err_q;
    logic [IdWidth-1:0]   done_id_q;

    function automatic logic [BeatBytes-1:0] beat_mask(
        input idx_t       idx,
        input idx_t       vstart,
        input idx_t       vl,
        input logic [1:0] vsew
    );
        logic [BeatBytes-1:0] m;
        idx_t                 e;
        m = '0;
        for (int b = 0; b < BeatBytes; b++) begin
            e    = idx + idx_t'(b >> vsew);
            m[b] = (e >= vstart) && (e < vl);
        end
        return m;
    endfunction

    idx_t req_vl;
    idx_t req_vstart;
    idx_t req_epb;
    idx_t req_first_idx;
    logic req_illegal;
    logic req_empty;
    idx_t cur_epb;
    idx_t next_idx;

    always_comb begin
        req_vl        = idx_t'(bus.req_vl_i);
        req_vstart    = idx_t'(bus.req_vstart_i);
        req_epb       = idx_t'(BeatBytes) >> bus.req_vsew_i;
        // EPB is a power of two, so masking rounds vstart down to a beat boundary.
        req_first_idx = req_vstart & ~(req_epb - idx_t'(1));
        req_illegal   = (bus.req_vsew_i == 2'd3);
        req_empty     = (req_vstart >= req_vl);
        cur_epb       = idx_t'(BeatBytes) >> vsew_q;
        next_idx      = idx_q + cur_epb;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            id_q         <= '0;
            vd_q         <= '0;
            vl_q         <= '0;
            vstart_q     <= '0;
            vsew_q       <= '0;
            idx_q        <= '0;
            beat_valid_q <= 1'b0;
            be_q         <= '0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            done_id_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        id_q     <= bus.req_id_i;
                        vd_q     <= bus.req_vd_i;
                        vl_q     <= req_vl;
                        vstart_q <= req_vstart;
                        vsew_q   <= bus.req_vsew_i;
                        if (req_illegal || req_empty) begin
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            err_q     <= req_illegal;
                            done_id_q <= bus.req_id_i;
                        end else begin
                            state_q      <= RUN;
                            beat_valid_q <= 1'b1;
                            idx_q        <= req_first_idx;
                            be_q         <= beat_mask(req_first_idx, req_vstart, req_vl,
                                                      bus.req_vsew_i);
                            first_q      <= 1'b1;
                            last_q       <= (req_first_idx + req_epb) >= req_vl;
                        end
                    end
                end
                RUN: begin
                    if (bus.beat_ready_i) begin
                        if (last_q) begin
                            state_q      <= DONE;
                            beat_valid_q <= 1'b0;
                            idx_q        <= '0;
                            be_q         <= '0;
                            first_q      <= 1'b0;
                            last_q       <= 1'b0;
                            done_q       <= 1'b1;
                            err_q        <= 1'b0;
                            done_id_q    <= id_q;
                        end else begin
                            idx_q   <= next_idx;
                            be_q    <= beat_mask(next_idx, vstart_q, vl_q, vsew_q);
                            first_q <= 1'b0;
                            last_q  <= (next_idx + cur_epb) >= vl_q;
                        end
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    done_q    <= 1'b0;
                    err_q     <= 1'b0;
                    done_id_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready_o     = (state_q == IDLE);
    assign bus.beat_valid_o    = beat_valid_q;
    assign bus.beat_id_o       = id_q;
    assign bus.beat_vd_o       = vd_q;
    assign bus.beat_elem_idx_o = idx_q[VlWidth-1:0];
    assign bus.beat_be_o       = be_q;
    assign bus.beat_first_o    = first_q;
    assign bus.beat_last_o     = last_q;
    assign bus.done_o          = done_q;
    assign bus.done_id_o       = done_id_q;
    assign bus.err_o           = err_q;
endmodule

// File: tb/tb_spatz_elem_seq.sv
// tb/tb_spatz_elem_seq.sv - directed self-checking bench for spatz_elem_seq
module tb_spatz_elem_seq;
    localparam int NrLanes = 4;
    localparam int VLEN    = 512;
    localparam int IdWidth = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spatz_elem_seq_if #(.NrLanes(NrLanes), .VLEN(VLEN), .IdWidth(IdWidth)) bus ();

    spatz_elem_seq #(.NrLanes(NrLanes), .VLEN(VLEN), .IdWidth(IdWidth)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    int          got_idx  [64];
    logic [15:0] got_be   [64];
    logic        got_first[64];
    logic        got_last [64];
    logic [4:0]  got_vd   [64];
    int          nb;
    logic        done_seen;
    int          done_cyc;
    logic [2:0]  done_id;
    logic        done_err;
    int          unstable;
    int          ready_high;

    task automatic send(input logic [2:0] id, input int vl, input int vstart,
                        input logic [1:0] vsew, input logic [4:0] vd);
        logic [31:0] vl_w;
        logic [31:0] vs_w;
        vl_w = vl;
        vs_w = vstart;
        bus.req_valid_i  = 1'b1;
        bus.req_id_i     = id;
        bus.req_vl_i     = vl_w[9:0];
        bus.req_vstart_i = vs_w[9:0];
        bus.req_vsew_i   = vsew;
        bus.req_vd_i     = vd;
        check("req_ready_idle", 32'(bus.req_ready_o), 1);
        @(posedge clk); #1;
        // Garbage after accept: the captured copy must be used.
        bus.req_valid_i  = 1'b0;
        bus.req_id_i     = 3'd0;
        bus.req_vl_i     = 10'd0;
        bus.req_vstart_i = 10'd0;
        bus.req_vsew_i   = 2'd3;
        bus.req_vd_i     = 5'd0;
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0 repeating
    task automatic collect(input int mode, input int budget);
        logic        rdy;
        logic        stalled;
        logic [63:0] snap;
        logic [63:0] held;
        nb         = 0;
        done_seen  = 1'b0;
        done_cyc   = -1;
        unstable   = 0;
        ready_high = 0;
        stalled    = 1'b0;
        held       = '0;
        for (int cyc = 0; cyc < budget && !done_seen; cyc++) begin
            rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            bus.beat_ready_i = rdy;
            @(negedge clk);
            if (bus.done_o) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                done_id   = bus.done_id_o;
                done_err  = bus.err_o;
            end else if (bus.req_ready_o) begin
                ready_high++;
            end
            if (bus.beat_valid_o) begin
                snap = {28'd0, bus.beat_elem_idx_o, bus.beat_be_o, bus.beat_first_o,
                        bus.beat_last_o, bus.beat_id_o, bus.beat_vd_o};
                if (stalled && snap != held) unstable++;
                held    = snap;
                stalled = !rdy;
                if (rdy && nb < 64) begin
                    got_idx[nb]   = int'(bus.beat_elem_idx_o);
                    got_be[nb]    = bus.beat_be_o;
                    got_first[nb] = bus.beat_first_o;
                    got_last[nb]  = bus.beat_last_o;
                    got_vd[nb]    = bus.beat_vd_o;
                    nb++;
                end
            end else begin
                stalled = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.beat_ready_i = 1'b0;
        if (!done_seen) begin
            check("done_timeout", 0, 1);
        end else begin
            @(negedge clk);
            check("done_one_cycle", 32'(bus.done_o), 0);
            check("ready_after_done", 32'(bus.req_ready_o), 1);
            check("no_beat_after_done", 32'(bus.beat_valid_o), 0);
            @(posedge clk); #1;
        end
    endtask

    int be_full;
    int last_cnt;

    initial begin
        bus.req_valid_i  = 1'b0;
        bus.req_id_i     = '0;
        bus.req_vl_i     = '0;
        bus.req_vstart_i = '0;
        bus.req_vsew_i   = '0;
        bus.req_vd_i     = '0;
        bus.beat_ready_i = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready_o), 1);
        check("rst_beat_valid", 32'(bus.beat_valid_o), 0);
        check("rst_done", 32'(bus.done_o), 0);
        check("rst_err", 32'(bus.err_o), 0);
        check("rst_be", 32'(bus.beat_be_o), 0);
        check("rst_idx", 32'(bus.beat_elem_idx_o), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // e32 vl=10 vstart=0, continuous ready
        send(3'd1, 10, 0, 2'd2, 5'd7);
        collect(0, 20);
        check("t1_nb", nb, 3);
        check("t1_idx0", got_idx[0], 0);
        check("t1_idx1", got_idx[1], 4);
        check("t1_idx2", got_idx[2], 8);
        check("t1_be0", 32'(got_be[0]), 32'hFFFF);
        check("t1_be1", 32'(got_be[1]), 32'hFFFF);
        check("t1_be2", 32'(got_be[2]), 32'h00FF);
        check("t1_first", {29'd0, got_first[0], got_first[1], got_first[2]}, 3'b100);
        check("t1_last", {29'd0, got_last[0], got_last[1], got_last[2]}, 3'b001);
        check("t1_vd", 32'(got_vd[0]), 7);
        check("t1_done_cyc", done_cyc, 3);
        check("t1_done_id", 32'(done_id), 1);
        check("t1_err", 32'(done_err), 0);
        check("t1_ready_busy", ready_high, 0);

        // e16 vstart=5 vl=7: single partial beat
        send(3'd2, 7, 5, 2'd1, 5'd3);
        collect(0, 10);
        check("t2_nb", nb, 1);
        check("t2_idx", got_idx[0], 0);
        check("t2_be", 32'(got_be[0]), 32'h3C00);
        check("t2_first_last", {30'd0, got_first[0], got_last[0]}, 2'b11);
        check("t2_done_cyc", done_cyc, 1);
        check("t2_done_id", 32'(done_id), 2);

        // e8 vl=VLEN
        send(3'd5, 512, 0, 2'd0, 5'd1);
        collect(0, 50);
        be_full  = 0;
        last_cnt = 0;
        for (int i = 0; i < nb; i++) begin
            if (got_be[i] == 16'hFFFF) be_full++;
            if (got_last[i]) last_cnt++;
        end
        check("t3_nb", nb, 32);
        check("t3_idx_last", got_idx[31], 496);
        check("t3_be_full", be_full, 32);
        check("t3_last_cnt", last_cnt, 1);
        check("t3_last_flag", 32'(got_last[31]), 1);
        check("t3_done_cyc", done_cyc, 32);
        check("t3_done_id", 32'(done_id), 5);

        // Backpressure, ready 1,0,0,...
        send(3'd4, 10, 0, 2'd2, 5'd2);
        collect(1, 40);
        check("t4_nb", nb, 3);
        check("t4_idx1", got_idx[1], 4);
        check("t4_idx2", got_idx[2], 8);
        check("t4_be2", 32'(got_be[2]), 32'h00FF);
        check("t4_stable", unstable, 0);
        check("t4_ready_busy", ready_high, 0);
        check("t4_done_cyc", done_cyc, 7);
        check("t4_done_id", 32'(done_id), 4);

        // Empty range
        send(3'd6, 0, 0, 2'd2, 5'd0);
        collect(0, 10);
        check("t5_nb", nb, 0);
        check("t5_done_cyc", done_cyc, 0);
        check("t5_err", 32'(done_err), 0);
        check("t5_done_id", 32'(done_id), 6);

        // Illegal vsew
        send(3'd7, 10, 0, 2'd3, 5'd0);
        collect(0, 10);
        check("t6_nb", nb, 0);
        check("t6_done_cyc", done_cyc, 0);
        check("t6_err", 32'(done_err), 1);
        check("t6_done_id", 32'(done_id), 7);

        // Reset while beat 1 is presented
        send(3'd1, 10, 0, 2'd2, 5'd9);
        bus.beat_ready_i = 1'b1;
        @(negedge clk);
        check("t7_beat0_idx", 32'(bus.beat_elem_idx_o), 0);
        @(posedge clk); #1;
        bus.beat_ready_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("t7_beat1_idx", 32'(bus.beat_elem_idx_o), 4);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t7_rst_valid", 32'(bus.beat_valid_o), 0);
        check("t7_rst_done", 32'(bus.done_o), 0);
        check("t7_rst_ready", 32'(bus.req_ready_o), 1);
        @(posedge clk); #1;
        send(3'd3, 7, 5, 2'd1, 5'd3);
        collect(0, 10);
        check("t7_nb", nb, 1);
        check("t7_be", 32'(got_be[0]), 32'h3C00);
        check("t7_done_cyc", done_cyc, 1);
        check("t7_done_id", 32'(done_id), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spatz_elem_seq.md
# spatz_elem_seq

Element sequencer sitting directly downstream of the vector CSR stage. It accepts one vector operation at a time, tagged with the `vl`, `vstart` and `vsew` values the CSR stage currently holds. It breaks the active element range `[vstart, vl)` into lane-wide beats with byte-enable masks. Beats are handed to the lane datapath over a valid/ready handshake, and completion is reported per operation.

## Interface
- `NrLanes`, default 4: number of lanes; each beat is one 32-bit word per lane, so `BeatBytes = 4*NrLanes`.
- `VLEN`, default 512: vector register length in bits.
- `IdWidth`, default 3: operation tag width.
- Derived: `VlWidth = $clog2(VLEN+1)` (10 at defaults).
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset. One clock; reset is synchronous and active-high.
- `req_valid_i`, in, 1: operation request valid.
- `req_ready_o`, out, 1: sequencer can accept a request.
- `req_id_i`, in, IdWidth: operation tag.
- `req_vl_i`, in, VlWidth: vector length.
- `req_vstart_i`, in, VlWidth: start element.
- `req_vsew_i`, in, 2: element width (0=e8, 1=e16, 2=e32, 3=e64).
- `req_vd_i`, in, 5: destination register.
- `beat_valid_o`, out, 1: beat valid.
- `beat_ready_i`, in, 1: lanes accept the beat.
- `beat_id_o`, out, IdWidth: tag of the owning operation.
- `beat_vd_o`, out, 5: destination register.
- `beat_elem_idx_o`, out, VlWidth: index of the first element slot in the beat (beat-aligned).
- `beat_be_o`, out, BeatBytes: byte enables.
- `beat_first_o`, out, 1: first beat of the operation.
- `beat_last_o`, out, 1: last beat of the operation.
- `done_o`, out, 1: one-cycle completion pulse.
- `done_id_o`, out, IdWidth: tag of the completed operation.
- `err_o`, out, 1: set together with `done_o` when the request was rejected.

## Operation
- FSM states and transitions:
  - IDLE: `req_ready_o=1`.
    - Handshake with a legal, non-empty range → RUN.
    - Handshake with an empty range or illegal vsew → DONE.
  - RUN: beats are issued. Handshake on the beat flagged last → DONE.
  - DONE: `done_o=1` for exactly one cycle → IDLE.
- Captured on accept: id, vd, vl, vstart, vsew. Inputs are ignored outside IDLE.
- Beat arithmetic:
  - Elements per beat `EPB = BeatBytes >> vsew`.
  - First beat index `floor(vstart/EPB)*EPB`; each beat adds EPB.
  - Last beat is the one containing element `vl-1`.
  - Beat count is `ceil(vl/EPB) - floor(vstart/EPB)`.
- Byte mask: the slot for element `e = beat_elem_idx_o + k` is enabled only if `vstart <= e < vl`. All `1<<vsew` bytes of slot k (bytes `k<<vsew` upward) share that enable.
- `beat_first_o` and `beat_last_o` may both be set on a single-beat operation.
- Empty range (`vl==0` or `vstart>=vl`): no beats; `done_o=1`, `err_o=0`.
- `vsew==3` (e64 not supported, ELEN=32): no beats; `done_o=1`, `err_o=1`.
- Index and count arithmetic uses VlWidth+1 bits internally, so `vl=VLEN` cannot wrap.

## Timing
- Reset: the state after any cycle with `rst_i=1` is:
  - IDLE, `req_ready_o=1`;
  - `beat_valid_o=0`, `done_o=0`, `err_o=0`;
  - all other outputs 0.
- Reset asserted mid-operation aborts the operation with no `done_o`.
- `req_ready_o` is driven combinationally from the state and is independent of `req_valid_i`.
- Request accepted at edge N: the first beat is valid in cycle N+1, or `done_o` in cycle N+1 for an empty/illegal request.
- Beats are registered outputs. While `beat_valid_o && !beat_ready_i`, all beat outputs hold stable.
- A beat handshake at edge M presents the next beat in cycle M+1, with no bubbles under continuous ready.
- Last-beat handshake at edge M: `done_o=1` in cycle M+1 and `req_ready_o=1` in cycle M+2.
- Minimum operation occupancy is beats+2 cycles.
- `done_o`/`done_id_o` and `err_o` are registered and valid only in the DONE cycle.

## Test plan
- **e32, vl=10, vstart=0, ready held high (defaults):**
  - beats at idx 0, 4, 8 in consecutive cycles;
  - be = 0xFFFF, 0xFFFF, 0x00FF;
  - first on beat 0, last on beat 2;
  - `done_o` one cycle after the last beat.
- **e16, vstart=5, vl=7:**
  - single beat, idx 0, be=0x3C00, first=last=1;
  - `done_o` with the correct id.
- **e8, vl=VLEN=512, vstart=0:**
  - 32 beats, all be=0xFFFF, last idx 496;
  - no index wrap.
- **Backpressure:** e32 vl=10 with `beat_ready_i` toggling 1,0,0,1,…
  - outputs stable while stalled, no beat lost or duplicated;
  - `req_ready_o=0` throughout.
- **Empty/illegal:**
  - vl=0 → `done_o=1` next cycle, `err_o=0`, no beat;
  - vsew=3 → `done_o=1`, `err_o=1`, no beat.
- **Reset mid-run:** assert `rst_i` during beat 1 of the e32 vl=10 case.
  - Next cycle: `beat_valid_o=0`, `done_o=0`, `req_ready_o=1`.
  - A new request then sequences correctly from scratch.
